// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters (CPU, loader) and the SRAM pads.
// The arbiter uses the slave modport; the requester/pad side uses master.
interface sram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;

    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic [15:0] ldr_rdata;
    logic        ldr_ack;

    logic [19:0] ADDR;
    logic        CE;
    logic        OE;
    logic        WE;
    logic        UB;
    logic        LB;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;

    logic        busy;
    logic        grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  Data_from_SRAM,
        output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        output ADDR, CE, OE, WE, UB, LB, Data_to_SRAM,
        output busy, grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output Data_from_SRAM,
        input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        input  ADDR, CE, OE, WE, UB, LB, Data_to_SRAM,
        input  busy, grant
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a CPU port and a loader port.
// state  | meaning
// IDLE   | no transaction; arbitrate and capture the winner's request
// ACCESS | strobes active for WAIT_CYCLES cycles; read data sampled on the last one
// ACK    | strobes released, one-cycle ack to the owner, then back to IDLE
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic     Clk,
    input  logic     Reset,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ldr_rdata_q, ldr_rdata_d;
    logic        pick_ldr;
    logic        in_access;

    // Loader wins when it is alone, or when both ask and the CPU was served last.
    assign pick_ldr = bus.ldr_req & (~bus.cpu_req | ~last_q);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    grant_d = pick_ldr;
                    last_d  = pick_ldr;
                    we_d    = pick_ldr ? bus.ldr_we    : bus.cpu_we;
                    addr_d  = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    wdata_d = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    if (!we_q) begin
                        if (grant_q) ldr_rdata_d = bus.Data_from_SRAM;
                        else         cpu_rdata_d = bus.Data_from_SRAM;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_access = (state_q == ACCESS);

    assign bus.CE           = ~in_access;
    assign bus.UB           = ~in_access;
    assign bus.LB           = ~in_access;
    assign bus.OE           = ~(in_access & ~we_q);
    assign bus.WE           = ~(in_access & we_q);
    assign bus.ADDR         = {4'b0000, addr_q};
    assign bus.Data_to_SRAM = wdata_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.grant        = grant_q;
    assign bus.cpu_ack      = (state_q == ACK) & ~grant_q;
    assign bus.ldr_ack      = (state_q == ACK) & grant_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.ldr_rdata    = ldr_rdata_q;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, number of cycles the SRAM strobes are held per access; legal range is 1..15.
REQ-002 Port: Clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: Reset  in  1  reset, synchronous and active-low.
REQ-004 Port: cpu_req / cpu_we  in  1 / 1  CPU access request and write select (1 = write).
REQ-005 Port: cpu_addr / cpu_wdata  in  16 / 16  CPU address and write data.
REQ-006 Port: cpu_rdata / cpu_ack  out  16 / 1  CPU read data and one-cycle completion pulse.
REQ-007 Port: ldr_req / ldr_we / ldr_addr / ldr_wdata  in  1/1/16/16  loader/debug port request, same meaning as the CPU inputs.
REQ-008 Port: ldr_rdata / ldr_ack  out  16 / 1  loader read data and completion pulse.
REQ-009 Port: ADDR  out  20  SRAM address, equal to {4'b0000, captured 16-bit address}.
REQ-010 Port: CE, OE, WE, UB, LB  out  1 each  SRAM strobes, all active-low.
REQ-011 Port: Data_to_SRAM / Data_from_SRAM  out / in  16 / 16  write data to the tristate, read data from the tristate.
REQ-012 Port: busy / grant  out  1 / 1  transaction in progress; current owner (0 = CPU, 1 = loader).

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and ACK.
REQ-014 IDLE: if at least one req is high at a clock edge, the arbiter grants one requester, captures that requester's addr, we and wdata, and moves to ACCESS.
REQ-015 Arbitration is round-robin: when both req are high, the grant goes to the requester that was not granted last; when only one req is high, that requester is granted.
REQ-016 ACCESS lasts exactly WAIT_CYCLES cycles, counted by an internal counter that is loaded on entry, then the FSM moves to ACK.
REQ-017 ACCESS strobes: CE=0, UB=0, LB=0; for a read OE=0 and WE=1; for a write WE=0 and OE=1.
REQ-018 ADDR, grant and Data_to_SRAM SHALL stay constant throughout ACCESS and ACK.
REQ-019 Read data: Data_from_SRAM is registered into the granted port's rdata on the final ACCESS cycle.
REQ-020 rdata holds its value until the next read completes on that same port.
REQ-021 A write SHALL leave rdata unchanged.
REQ-022 ACK: all strobes are 1, the granted port's ack is 1 for exactly one cycle, and the other port's ack is 0; the FSM then returns to IDLE.
REQ-023 Latency: a req sampled in IDLE at edge k gives ACCESS over cycles k+1..k+WAIT_CYCLES and ack in cycle k+WAIT_CYCLES+1.
REQ-024 A requester SHALL deassert req by the edge that ends its ACK cycle; a req still high in IDLE after that edge is treated as a new request.
REQ-025 A req that drops during ACCESS SHALL not abort the transaction; the transaction completes and ack still pulses.
REQ-026 A req from the non-granted port that arrives during ACCESS or ACK is held off until IDLE and is then served.
REQ-027 busy=1 in ACCESS and ACK, and busy=0 in IDLE.
REQ-028 In IDLE and ACK: CE=OE=WE=UB=LB=1.
REQ-029 Data_to_SRAM holds the last captured wdata.

Reset
REQ-030 On a rising edge with Reset=0, the block SHALL enter IDLE.
REQ-031 Reset values: CE=OE=WE=UB=LB=1, ADDR=0, Data_to_SRAM=0, cpu_rdata=ldr_rdata=0, both ack=0, busy=0, grant=0.
REQ-032 After reset the last-grant record is set to "loader", so the CPU wins the first contended arbitration.
REQ-033 Reset asserted during ACCESS or ACK aborts the transaction with no ack; strobes are 1 in the cycle after the reset edge.
REQ-034 Reset has priority over every other event on the same edge.

Verification
REQ-035 Single CPU read, WAIT_CYCLES=2, cpu_addr=0x1234, Data_from_SRAM=0xBEEF -> ADDR=0x01234 and OE=0 for 2 cycles, then cpu_ack pulses once and cpu_rdata=0xBEEF.
REQ-036 Loader write of 0xA5A5 to address 0x0040 -> WE=0 and OE=1 for 2 cycles with Data_to_SRAM=0xA5A5; ldr_ack pulses; cpu_rdata is unchanged.
REQ-037 cpu_req and ldr_req both held high from reset release -> grants alternate CPU, loader, CPU, with each ack arriving WAIT_CYCLES+1 cycles after its grant.
REQ-038 cpu_req dropped during the first ACCESS cycle -> the transaction still completes and cpu_ack pulses at the normal cycle.
REQ-039 Reset=0 in the second ACCESS cycle -> no ack, all strobes=1 and busy=0 on the next cycle, and the first contended grant afterwards goes to the CPU.
REQ-040 WAIT_CYCLES=1, back-to-back CPU reads with req re-raised immediately -> strobes are active 1 cycle in every 3, and rdata updates each time.
